// File: rtl/trena_rx_medida.sv
`default_nettype none
// ============================================================================
// Module   : trena_rx_medida
// Purpose  : Receives a distance measurement from a UART byte stream. A frame
//            is three ASCII digits (hundreds, tens, units) followed by '#'.
//            Each byte is validated. The value is published as BCD and as
//            binary. A completed frame pulses medida_valida, and a rejected
//            frame pulses erro.
// Ports    : clock, reset (async, active-high), habilita (frame enable),
//            dado_rx[7:0] / pronto_rx (byte + strobe from UART receiver),
//            medida_centena/dezena/unidade[3:0] (BCD of last good frame),
//            medida_bin[9:0] (binary of last good frame),
//            medida_valida / erro (one-cycle status pulses),
//            db_estado[3:0] (debug state code).
// Options  : RX_TIMEOUT_EN - when defined, the design includes an inter-byte
//            timeout of TIMEOUT_CICLOS clock cycles.
// Revision : 1.0 - initial release
// ============================================================================
module trena_rx_medida #(
  parameter int TIMEOUT_CICLOS = 5000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       habilita,
  input  logic [7:0] dado_rx,
  input  logic       pronto_rx,
  output logic [3:0] medida_centena,
  output logic [3:0] medida_dezena,
  output logic [3:0] medida_unidade,
  output logic [9:0] medida_bin,
  output logic       medida_valida,
  output logic       erro,
  output logic [3:0] db_estado
);

  // State codes double as the debug codes shown on db_estado.
  localparam logic [3:0] S_INICIAL  = 4'h0;
  localparam logic [3:0] S_ESP_CEN  = 4'h1;
  localparam logic [3:0] S_ESP_DEZ  = 4'h2;
  localparam logic [3:0] S_ESP_UNI  = 4'h3;
  localparam logic [3:0] S_ESP_HASH = 4'h4;
  localparam logic [3:0] S_FINAL    = 4'hF;
  localparam logic [3:0] S_ERRO     = 4'hE;
  localparam logic [3:0] C_DB_INVAL = 4'hD;
  localparam logic [7:0] C_HASH     = 8'h23;

  logic [3:0] r_estado;
  logic [3:0] w_prox;
  logic [3:0] r_cen;
  logic [3:0] r_dez;
  logic [3:0] r_uni;
  logic       w_digito;
  logic       w_espera_byte;
  logic       w_expira;
  logic [9:0] w_bin;

  assign w_digito = (dado_rx >= 8'h30) && (dado_rx <= 8'h39);

  // These states count toward the inter-byte timeout. espera_centena is excluded.
  assign w_espera_byte = (r_estado == S_ESP_DEZ) || (r_estado == S_ESP_UNI) ||
                         (r_estado == S_ESP_HASH);

`ifdef RX_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CICLOS > 1) ? $clog2(TIMEOUT_CICLOS) : 1;
  localparam logic [CW-1:0] C_TMO_MAX = CW'(TIMEOUT_CICLOS - 1);

  logic [CW-1:0] r_tmo;
  logic          w_conta;

  // The counter runs only while a frame is waiting for its next byte. Any
  // byte, leaving the waiting states, or dropping habilita brings it back
  // to zero.
  assign w_conta  = w_espera_byte && habilita && !pronto_rx;
  assign w_expira = w_espera_byte && (r_tmo == C_TMO_MAX);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_tmo <= '0;
    end else if (w_conta) begin
      r_tmo <= r_tmo + 1'b1;
    end else begin
      r_tmo <= '0;
    end
  end
`else
  // No timeout is built. The parameter is folded into a constant-zero term
  // so it still counts as referenced.
  assign w_expira = 1'b0 & (TIMEOUT_CICLOS > 0);
`endif

  // Next-state logic. habilita=0 takes priority over a byte, and a byte
  // takes priority over timeout expiry.
  always_comb begin
    w_prox = r_estado;
    case (r_estado)
      S_INICIAL: begin
        if (habilita) w_prox = S_ESP_CEN;
      end
      S_ESP_CEN: begin
        if (!habilita)      w_prox = S_INICIAL;
        else if (pronto_rx) w_prox = w_digito ? S_ESP_DEZ : S_ERRO;
      end
      S_ESP_DEZ: begin
        if (!habilita)      w_prox = S_INICIAL;
        else if (pronto_rx) w_prox = w_digito ? S_ESP_UNI : S_ERRO;
        else if (w_expira)  w_prox = S_ERRO;
      end
      S_ESP_UNI: begin
        if (!habilita)      w_prox = S_INICIAL;
        else if (pronto_rx) w_prox = w_digito ? S_ESP_HASH : S_ERRO;
        else if (w_expira)  w_prox = S_ERRO;
      end
      S_ESP_HASH: begin
        if (!habilita)      w_prox = S_INICIAL;
        else if (pronto_rx) w_prox = (dado_rx == C_HASH) ? S_FINAL : S_ERRO;
        else if (w_expira)  w_prox = S_ERRO;
      end
      S_FINAL:  w_prox = S_INICIAL;
      S_ERRO:   w_prox = S_INICIAL;
      default:  w_prox = S_INICIAL;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= S_INICIAL;
    else       r_estado <= w_prox;
  end

  // Temporary digit registers hold the frame that is being received.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cen <= 4'd0;
      r_dez <= 4'd0;
      r_uni <= 4'd0;
    end else if (r_estado == S_ERRO) begin
      r_cen <= 4'd0;
      r_dez <= 4'd0;
      r_uni <= 4'd0;
    end else if (habilita && pronto_rx && w_digito) begin
      if (r_estado == S_ESP_CEN) r_cen <= dado_rx[3:0];
      if (r_estado == S_ESP_DEZ) r_dez <= dado_rx[3:0];
      if (r_estado == S_ESP_UNI) r_uni <= dado_rx[3:0];
    end
  end

  // c*100 = c*64 + c*32 + c*4 and d*10 = d*8 + d*2. For digits up to 9 the
  // result is at most 999, so it fits in 10 bits.
  assign w_bin = ({6'd0, r_cen} << 6) + ({6'd0, r_cen} << 5) + ({6'd0, r_cen} << 2) +
                 ({6'd0, r_dez} << 3) + ({6'd0, r_dez} << 1) + {6'd0, r_uni};

  // The published measurement updates only on the edge that leaves final.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      medida_centena <= 4'd0;
      medida_dezena  <= 4'd0;
      medida_unidade <= 4'd0;
      medida_bin     <= 10'd0;
    end else if (r_estado == S_FINAL) begin
      medida_centena <= r_cen;
      medida_dezena  <= r_dez;
      medida_unidade <= r_uni;
      medida_bin     <= w_bin;
    end
  end

  assign medida_valida = (r_estado == S_FINAL);
  assign erro          = (r_estado == S_ERRO);

  always_comb begin
    db_estado = C_DB_INVAL;
    case (r_estado)
      S_INICIAL, S_ESP_CEN, S_ESP_DEZ, S_ESP_UNI,
      S_ESP_HASH, S_FINAL, S_ERRO: db_estado = r_estado;
      default:                     db_estado = C_DB_INVAL;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_trena_rx_medida.sv
`default_nettype none
// ============================================================================
// Module   : tb_trena_rx_medida
// Purpose  : Self-checking bench for trena_rx_medida. The stimulus process
//            queues the expected status and outputs of each frame. A monitor
//            pops one entry each time medida_valida or erro pulses and
//            compares it with the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_trena_rx_medida;

  logic       clock = 1'b0;
  logic       reset;
  logic       habilita;
  logic [7:0] dado_rx;
  logic       pronto_rx;
  logic [3:0] medida_centena;
  logic [3:0] medida_dezena;
  logic [3:0] medida_unidade;
  logic [9:0] medida_bin;
  logic       medida_valida;
  logic       erro;
  logic [3:0] db_estado;

  trena_rx_medida #(.TIMEOUT_CICLOS(100)) dut (
    .clock          (clock),
    .reset          (reset),
    .habilita       (habilita),
    .dado_rx        (dado_rx),
    .pronto_rx      (pronto_rx),
    .medida_centena (medida_centena),
    .medida_dezena  (medida_dezena),
    .medida_unidade (medida_unidade),
    .medida_bin     (medida_bin),
    .medida_valida  (medida_valida),
    .erro           (erro),
    .db_estado      (db_estado)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit         is_err;
    logic [3:0] c;
    logic [3:0] d;
    logic [3:0] u;
    logic [9:0] b;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  task automatic push(input bit is_err, input int c, input int d, input int u, input int b);
    exp_t e;
    e.is_err = is_err;
    e.c = 4'(c);
    e.d = 4'(d);
    e.u = 4'(u);
    e.b = 10'(b);
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clock);
  endtask

  // The byte is driven for one full cycle around a rising edge. The task
  // returns at the falling edge after that rising edge.
  task automatic send_byte(input logic [7:0] b);
    @(negedge clock);
    dado_rx   = b;
    pronto_rx = 1'b1;
    @(negedge clock);
    pronto_rx = 1'b0;
    dado_rx   = 8'h00;
  endtask

  task automatic send_frame(input logic [7:0] b0, input logic [7:0] b1,
                            input logic [7:0] b2, input logic [7:0] b3);
    send_byte(b0); idle(1);
    send_byte(b1); idle(1);
    send_byte(b2); idle(1);
    send_byte(b3);
  endtask

  // Monitor: each status pulse consumes one expected entry. The outputs are
  // then compared one cycle later, when the registered values are visible.
  initial begin
    exp_t e;
    forever begin
      @(negedge clock);
      if (!reset && (medida_valida || erro)) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", {30'd0, medida_valida, erro}, 32'd0);
        end else begin
          e = q.pop_front();
          chk("pulse_kind", {30'd0, medida_valida, erro}, e.is_err ? 32'd1 : 32'd2);
          @(negedge clock);
          chk("pulse_width", {30'd0, medida_valida, erro}, 32'd0);
          chk("centena", 32'(medida_centena), 32'(e.c));
          chk("dezena",  32'(medida_dezena),  32'(e.d));
          chk("unidade", 32'(medida_unidade), 32'(e.u));
          chk("bin",     32'(medida_bin),     32'(e.b));
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  cnt;
    bit  saw;
    reset     = 1'b1;
    habilita  = 1'b0;
    dado_rx   = 8'h00;
    pronto_rx = 1'b0;
    idle(2);
    // Reset state
    chk("rst_centena", 32'(medida_centena), 32'd0);
    chk("rst_bin",     32'(medida_bin),     32'd0);
    chk("rst_valida",  32'(medida_valida),  32'd0);
    chk("rst_erro",    32'(erro),           32'd0);
    chk("rst_estado",  32'(db_estado),      32'd0);
    reset = 1'b0;
    idle(1);
    habilita = 1'b1;
    idle(2);
    chk("espera_centena", 32'(db_estado), 32'd1);

    // 1: normal frame 123
    push(0, 1, 2, 3, 123);
    send_frame(8'h31, 8'h32, 8'h33, 8'h23);
    idle(4);

    // 2: bad tens byte; outputs hold 123. Then frame 999.
    push(1, 1, 2, 3, 123);
    send_byte(8'h34); idle(1);
    send_byte(8'h41);
    idle(4);
    push(0, 9, 9, 9, 999);
    send_frame(8'h39, 8'h39, 8'h39, 8'h23);
    idle(4);

    // 3: no '#'. The state sequence is E, then 0, then 1.
    push(1, 9, 9, 9, 999);
    send_byte(8'h30); idle(1);
    send_byte(8'h35); idle(1);
    send_byte(8'h37); idle(1);
    send_byte(8'h30);
    chk("t3_estado_erro", 32'(db_estado), 32'hE);
    @(negedge clock);
    chk("t3_estado_ini", 32'(db_estado), 32'd0);
    @(negedge clock);
    chk("t3_estado_cen", 32'(db_estado), 32'd1);
    idle(2);

    // 5: drop habilita mid-frame. No erro. Then frame 007.
    send_byte(8'h31); idle(1);
    send_byte(8'h32);
    habilita = 1'b0;
    @(negedge clock);
    chk("t5_estado_ini", 32'(db_estado), 32'd0);
    habilita = 1'b1;
    @(negedge clock);
    chk("t5_estado_cen", 32'(db_estado), 32'd1);
    push(0, 0, 0, 7, 7);
    send_frame(8'h30, 8'h30, 8'h37, 8'h23);
    idle(4);

    // 4: inter-byte timeout after the first digit
    send_byte(8'h35);
    chk("t4_espera_dezena", 32'(db_estado), 32'd2);
`ifdef RX_TIMEOUT_EN
    push(1, 0, 0, 7, 7);
    cnt = 0;
    saw = 1'b0;
    while (cnt < 200 && !saw) begin
      @(negedge clock);
      cnt++;
      if (erro) saw = 1'b1;
    end
    chk("t4_timeout_cycles", 32'(cnt), 32'd100);
    idle(4);
`else
    saw = 1'b0;
    repeat (300) begin
      @(negedge clock);
      if (erro || db_estado != 4'd2) saw = 1'b1;
    end
    chk("t4_no_timeout", 32'(saw), 32'd0);
    habilita = 1'b0;
    @(negedge clock);
    habilita = 1'b1;
    idle(3);
`endif

    // 6: asynchronous reset mid-frame, then frame 345
    send_byte(8'h31); idle(1);
    send_byte(8'h32);
    chk("t6_espera_unidade", 32'(db_estado), 32'd3);
    #1 reset = 1'b1;
    #1;
    chk("t6_async_estado", 32'(db_estado), 32'd0);
    chk("t6_async_bin",    32'(medida_bin), 32'd0);
    chk("t6_async_dig",    32'({medida_centena, medida_dezena, medida_unidade}), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    idle(3);
    push(0, 3, 4, 5, 345);
    send_frame(8'h33, 8'h34, 8'h35, 8'h23);
    idle(6);

    chk("queue_drained", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/trena_rx_medida.md
Name: trena_rx_medida

Overview:
Receiver-side counterpart of the distance-sensor transmit sequence. It consumes bytes from a UART receiver and expects one frame of three ASCII digits (centena, dezena, unidade) followed by '#' (0x23). It validates each byte, assembles the measurement as BCD and as binary, and flags completed frames or errors. It sits between the serial receiver and the display or comparison logic.

Parameters:
TIMEOUT_CICLOS, 5000000, maximum clock cycles allowed between consecutive bytes of one frame (100 ms at 50 MHz); counter width = clog2(TIMEOUT_CICLOS).

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
habilita  input  1  level; 1 = accept frames, 0 = idle and discard any partial frame
dado_rx  input  8  received byte; valid only when pronto_rx=1
pronto_rx  input  1  one-cycle pulse, byte available
medida_centena  output  4  BCD hundreds of last valid frame
medida_dezena  output  4  BCD tens of last valid frame
medida_unidade  output  4  BCD units of last valid frame
medida_bin  output  10  binary value centena*100+dezena*10+unidade, range 0..999
medida_valida  output  1  one-cycle pulse, frame accepted
erro  output  1  one-cycle pulse, frame rejected
db_estado  output  4  debug state code

Behaviour:
- Reset: state inicial; all outputs 0; temporary digit registers 0; timeout counter 0.
- States and db_estado codes: inicial=0, espera_centena=1, espera_dezena=2, espera_unidade=3, espera_hash=4, final=F, erro_st=E. Any unused encoding goes to inicial and shows db_estado=D.
- inicial: go to espera_centena when habilita=1.
- espera_centena, espera_dezena, espera_unidade:
  - pronto_rx=1 with dado_rx in 0x30..0x39: store dado_rx[3:0] in that digit's temporary register; advance to the next state.
  - pronto_rx=1 with any other byte: go to erro_st.
- espera_hash:
  - pronto_rx=1 with dado_rx=0x23: go to final.
  - pronto_rx=1 with any other byte: go to erro_st.
- final (one cycle):
  - On the clock edge leaving final, copy the temporary registers to medida_centena, medida_dezena and medida_unidade, and register medida_bin.
  - medida_valida=1 while in final (Moore output). Registered outputs become visible in the cycle after medida_valida.
  - Next state: inicial.
- erro_st (one cycle): erro=1; clear the temporary registers; output registers keep the last valid measurement; next state inicial.
- habilita=0 in any espera_* state: go to inicial at the next edge. The partial frame is discarded and no erro pulse is produced. habilita has priority over pronto_rx.
- Bytes arriving in inicial, final or erro_st are ignored. The frame restarts at espera_centena.
- Timeout:
  - The counter clears on entering espera_centena and on every accepted byte.
  - It increments only in espera_dezena, espera_unidade and espera_hash.
  - When it reaches TIMEOUT_CICLOS-1 with no pronto_rx, go to erro_st.
  - If pronto_rx and timeout expiry fall in the same cycle, the byte wins.
  - espera_centena never times out.
- Arithmetic: medida_bin = c*100 + d*10 + u. Use shift-add (c<<6 + c<<5 + c<<2, d<<3 + d<<1), computed in 10 bits with no overflow.
- Latency: last byte ('#') at edge N puts the block in final at cycle N+1. medida_valida is high during N+1; outputs update at edge N+2.

Optional Feature:
Macro RX_TIMEOUT_EN.
- Defined: the inter-byte timeout is built as described above.
- Undefined: no counter is synthesised and espera_* states wait indefinitely. TIMEOUT_CICLOS is unused. All other behaviour is identical.

Test Plan:
1. habilita=1; send 0x31, 0x32, 0x33, 0x23 → medida_valida pulse for 1 cycle; then centena=1, dezena=2, unidade=3, medida_bin=123, erro=0.
2. After test 1, send 0x34, 0x41, ... → erro pulse on the 0x41 byte; outputs remain 1/2/3/123; the next frame 0x39, 0x39, 0x39, 0x23 gives medida_bin=999.
3. Send 0x30, 0x35, 0x37, 0x30 (no '#') → erro pulse; medida_valida stays 0; state returns to 0 then 1.
4. With TIMEOUT_CICLOS=100 and RX_TIMEOUT_EN defined: send 0x35 then nothing → erro exactly 100 cycles after entering espera_dezena. Repeat with RX_TIMEOUT_EN undefined → db_estado stays 2 indefinitely.
5. Send 0x31, 0x32, then drop habilita for 1 cycle → db_estado=0 with no erro; re-assert habilita and send a full frame 0x30, 0x30, 0x37, 0x23 → medida_bin=7.
6. Assert reset mid-frame (in espera_unidade) → all outputs 0 and db_estado=0 immediately (asynchronous); after release, a full frame is accepted normally.
